// File: rtl/ps_frame_sequencer_pkg.sv
// Shared types for the frame sequencer: FSM state encoding and error codes.
package ps_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_ERROR  = 3'd5
  } ps_state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_LINE_LEN  = 2'd1,
    ERR_EARLY_SOF = 2'd2,
    ERR_DRAIN_TMO = 2'd3
  } ps_err_t;

endpackage

// File: rtl/ps_frame_sequencer_raster_counter.sv
// Raster position tracker: column/row of the next expected pixel in a frame.
// Restart marks the SOF pixel as consumed, so the next pixel is (col 1, row 0).
module ps_frame_sequencer_raster_counter #(
  parameter int LINE_LENGTH = 640,
  parameter int LINE_COUNT  = 480
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_advance,
  output logic o_eol_expected,
  output logic o_last_pixel
);

  localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int ROW_W = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LENGTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINE_COUNT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Column counter wraps at the end of each line and carries into the row counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (i_restart) begin
      col <= COL_W'(1);
      row <= '0;
    end else if (i_advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign o_eol_expected = (col == COL_LAST);
  assign o_last_pixel   = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/ps_frame_sequencer.sv
// Frame-level controller in front of the kernel control block: forwards one
// raster frame, injects zero lines to drain the line buffers, counts output
// windows, clears the kernel between frames and traps malformed frames.
//
// state  | meaning
// IDLE   | waiting for SOF (when armed); non-SOF pixels discarded
// STREAM | forwarding frame pixels, checking EOL/SOF placement
// FLUSH  | writing zero lines into the kernel so bottom rows complete
// DRAIN  | waiting for the remaining windows, bounded by a timeout
// CLEAR  | holding kernel clear for a fixed number of cycles
// ERROR  | kernel held in clear, upstream swallowed until acknowledged
module ps_frame_sequencer
  import ps_frame_sequencer_pkg::*;
#(
  parameter int LINE_LENGTH   = 640,
  parameter int LINE_COUNT    = 480,
  parameter int DATA_WIDTH    = 1,
  parameter int FLUSH_LINES   = 1,
  parameter int CLEAR_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_enable,
  input  logic                                         i_err_clr,
  input  logic [DATA_WIDTH-1:0]                        i_data,
  input  logic                                         i_valid,
  input  logic                                         i_sof,
  input  logic                                         i_eol,
  output logic                                         o_ready,
  output logic [DATA_WIDTH-1:0]                        o_kc_data,
  output logic                                         o_kc_valid,
  input  logic                                         i_kc_req,
  output logic                                         o_kc_clear,
  input  logic                                         i_win_valid,
  output logic                                         o_busy,
  output logic                                         o_frame_done,
  output logic [$clog2(LINE_LENGTH*LINE_COUNT+1)-1:0]  o_win_count,
  output logic                                         o_err,
  output logic [1:0]                                   o_err_code
);

  localparam int WIN_W   = $clog2(LINE_LENGTH * LINE_COUNT + 1);
  localparam int FLUSH_N = FLUSH_LINES * LINE_LENGTH;
  localparam int FLUSH_W = $clog2(FLUSH_N + 1);
  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int CLR_W   = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES + 1) : 1;

  localparam logic [WIN_W-1:0]   WIN_MAX    = WIN_W'(LINE_LENGTH * LINE_COUNT);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_N - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CLR_W-1:0]   CLR_LOAD   = CLR_W'(CLEAR_CYCLES - 1);

  ps_state_t          state;
  ps_err_t            err_code;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [DRAIN_W-1:0] drain_tmr;
  logic [CLR_W-1:0]   clr_tmr;

  logic sof_xfer;
  logic stream_xfer;
  logic flush_xfer;
  logic eol_expected;
  logic last_pixel;
  logic win_inc;

  // Transfer qualifiers; reset blocks any handshake in the reset cycle.
  assign sof_xfer    = (state == ST_IDLE) && i_enable && i_valid && i_sof && i_kc_req && !i_rst;
  assign stream_xfer = (state == ST_STREAM) && i_valid && i_kc_req && !i_rst;
  assign flush_xfer  = (state == ST_FLUSH) && i_kc_req && !i_rst;
  assign win_inc     = i_win_valid && (o_win_count != WIN_MAX) &&
                       ((state == ST_STREAM) || (state == ST_FLUSH) || (state == ST_DRAIN));

  assign o_busy     = (state != ST_IDLE);
  assign o_err_code = err_code;

  ps_frame_sequencer_raster_counter #(
    .LINE_LENGTH (LINE_LENGTH),
    .LINE_COUNT  (LINE_COUNT)
  ) u_raster (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_restart      (sof_xfer),
    .i_advance      (stream_xfer),
    .o_eol_expected (eol_expected),
    .o_last_pixel   (last_pixel)
  );

  // Zero-latency datapath steering between upstream, kernel and flush zeros.
  always_comb begin
    o_ready    = 1'b0;
    o_kc_valid = 1'b0;
    o_kc_data  = i_data;
    case (state)
      ST_IDLE: begin
        o_ready    = i_enable && (!i_sof || i_kc_req);
        o_kc_valid = i_enable && i_valid && i_sof && i_kc_req;
      end
      ST_STREAM: begin
        o_ready    = i_kc_req;
        o_kc_valid = i_valid && i_kc_req;
      end
      ST_FLUSH: begin
        o_kc_valid = i_kc_req;
        o_kc_data  = '0;
      end
      ST_ERROR: begin
        o_ready = 1'b1;
      end
      default: begin
        o_ready    = 1'b0;
        o_kc_valid = 1'b0;
      end
    endcase
    if (i_rst) begin
      o_ready    = 1'b0;
      o_kc_valid = 1'b0;
    end
  end

  // Frame sequencing FSM with registered status outputs and down-counting timers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      err_code     <= ERR_NONE;
      o_err        <= 1'b0;
      o_kc_clear   <= 1'b1;
      o_frame_done <= 1'b0;
      o_win_count  <= '0;
      flush_cnt    <= '0;
      drain_tmr    <= '0;
      clr_tmr      <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (win_inc) begin
        o_win_count <= o_win_count + WIN_W'(1);
      end
      case (state)
        ST_IDLE: begin
          o_kc_clear <= 1'b0;
          if (sof_xfer) begin
            state       <= ST_STREAM;
            o_win_count <= '0;
          end
        end
        ST_STREAM: begin
          if (stream_xfer) begin
            if (i_eol != eol_expected) begin
              state      <= ST_ERROR;
              err_code   <= ERR_LINE_LEN;
              o_err      <= 1'b1;
              o_kc_clear <= 1'b1;
            end else if (i_sof) begin
              state      <= ST_ERROR;
              err_code   <= ERR_EARLY_SOF;
              o_err      <= 1'b1;
              o_kc_clear <= 1'b1;
            end else if (last_pixel) begin
              state     <= ST_FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_xfer) begin
            if (flush_cnt == '0) begin
              state     <= ST_DRAIN;
              drain_tmr <= DRAIN_LOAD;
            end else begin
              flush_cnt <= flush_cnt - FLUSH_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (o_win_count == WIN_MAX) begin
            state        <= ST_CLEAR;
            o_frame_done <= 1'b1;
            o_kc_clear   <= 1'b1;
            clr_tmr      <= CLR_LOAD;
          end else if (i_win_valid) begin
            drain_tmr <= DRAIN_LOAD;
          end else if (drain_tmr == '0) begin
            state      <= ST_ERROR;
            err_code   <= ERR_DRAIN_TMO;
            o_err      <= 1'b1;
            o_kc_clear <= 1'b1;
          end else begin
            drain_tmr <= drain_tmr - DRAIN_W'(1);
          end
        end
        ST_CLEAR: begin
          if (clr_tmr == '0) begin
            state      <= ST_IDLE;
            o_kc_clear <= 1'b0;
          end else begin
            clr_tmr <= clr_tmr - CLR_W'(1);
          end
        end
        ST_ERROR: begin
          if (i_err_clr) begin
            state      <= ST_IDLE;
            err_code   <= ERR_NONE;
            o_err      <= 1'b0;
            o_kc_clear <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps_frame_sequencer.sv
// Scoreboard bench for ps_frame_sequencer with a behavioural kernel-control stand-in.
module tb_ps_frame_sequencer;

  localparam int LL = 8;
  localparam int LC = 6;
  localparam int FL = 1;
  localparam int CC = 2;
  localparam int DT = 16;
  localparam int WW = $clog2(LL * LC + 1);

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_err_clr = 1'b0;
  logic [0:0]    i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_sof = 1'b0;
  logic          i_eol = 1'b0;
  logic          o_ready;
  logic [0:0]    o_kc_data;
  logic          o_kc_valid;
  logic          i_kc_req = 1'b1;
  logic          o_kc_clear;
  logic          i_win_valid = 1'b0;
  logic          o_busy;
  logic          o_frame_done;
  logic [WW-1:0] o_win_count;
  logic          o_err;
  logic [1:0]    o_err_code;

  ps_frame_sequencer #(
    .LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(1),
    .FLUSH_LINES(FL), .CLEAR_CYCLES(CC), .DRAIN_TIMEOUT(DT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_err_clr(i_err_clr),
    .i_data(i_data), .i_valid(i_valid), .i_sof(i_sof), .i_eol(i_eol),
    .o_ready(o_ready), .o_kc_data(o_kc_data), .o_kc_valid(o_kc_valid),
    .i_kc_req(i_kc_req), .o_kc_clear(o_kc_clear), .i_win_valid(i_win_valid),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_win_count(o_win_count),
    .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_pulses = 0;
  int last_xfer_edge = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Kernel-control stand-in: windows appear one cycle after each accepted
  // pixel once the first FLUSH_LINES lines are buffered.
  bit kc_rand = 0;
  bit kc_silent = 0;
  int kc_cnt = 0;
  logic acc_n = 1'b0;
  logic clr_n = 1'b1;

  // Monitor: pops the scoreboard on every kernel write.
  always @(negedge clk) begin
    acc_n = o_kc_valid & i_kc_req;
    clr_n = o_kc_clear;
    if (o_frame_done === 1'b1) done_pulses++;
    if (acc_n === 1'b1) begin
      last_xfer_edge = cyc + 1;
      if (exp_q.size() == 0) begin
        check("unexpected_fwd", {63'd0, o_kc_data}, 64'd999);
      end else begin
        check("fwd_data", {63'd0, o_kc_data}, {63'd0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (clr_n !== 1'b0) begin
      kc_cnt = 0;
      i_win_valid = 1'b0;
    end else begin
      i_win_valid = (acc_n === 1'b1) && (kc_cnt >= FL * LL) && !kc_silent;
      if (acc_n === 1'b1) kc_cnt++;
    end
    i_kc_req = kc_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Reference model: frame rules expressed on linear pixel position.
  bit m_in = 0;
  bit m_err = 0;
  int m_pos = 0;

  task automatic model_reset();
    m_in = 0; m_err = 0; m_pos = 0;
  endtask

  task automatic model_issue(input logic d, input logic sof, input logic eol, output int code);
    code = 0;
    if (!m_in) begin
      if (sof) begin
        exp_q.push_back(d);
        m_in = 1; m_err = 0; m_pos = 1;
      end
    end else if (!m_err) begin
      exp_q.push_back(d);
      if (eol != ((m_pos % LL) == LL - 1)) begin
        code = 1; m_err = 1;
      end else if (sof) begin
        code = 2; m_err = 1;
      end else begin
        m_pos++;
        if (m_pos == LL * LC) begin
          for (int k = 0; k < FL * LL; k++) exp_q.push_back(1'b0);
          m_in = 0;
        end
      end
    end
  endtask

  // Presents one pixel until accepted, then checks the error reaction if any.
  task automatic send_pixel(input logic d, input logic sof, input logic eol);
    int code;
    int n;
    model_issue(d, sof, eol, code);
    i_data = d; i_sof = sof; i_eol = eol; i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("ready_timeout", 1, 0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
    if (code != 0) begin
      check("err_flag", {63'd0, o_err}, 1);
      check("err_code", {62'd0, o_err_code}, code);
      check("err_kc_clear", {63'd0, o_kc_clear}, 1);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // kind: 0 clean, 1 short line at row 2, 2 early SOF at row 3.
  task automatic send_frame(input int kind, input bit gaps);
    for (int r = 0; r < LC; r++) begin
      if (gaps && r == 3) i_enable = 1'b0;
      for (int c = 0; c < LL; c++) begin
        send_pixel(1'($urandom_range(0, 1)),
                   (r == 0 && c == 0) || (kind == 2 && r == 3 && c == 0),
                   (c == LL - 1) || (kind == 1 && r == 2 && c == 5));
        if (gaps) idle_cycles($urandom_range(0, 2));
      end
    end
    i_enable = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    int d0;
    d0 = done_pulses;
    n = 0;
    @(negedge clk);
    while (o_frame_done !== 1'b1 && n < 600) begin
      n++;
      @(negedge clk);
    end
    if (n >= 600) begin
      check({tag, "_done_timeout"}, 1, 0);
    end else begin
      check({tag, "_win_count"}, o_win_count, LL * LC);
      n = 0;
      while (o_kc_clear === 1'b1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_clear_cycles"}, n, CC);
      check({tag, "_idle"}, {63'd0, o_busy}, 0);
      @(negedge clk);
      @(negedge clk);
      check({tag, "_done_pulses"}, done_pulses - d0, 1);
      check({tag, "_count_hold"}, o_win_count, LL * LC);
    end
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic ack_error(input string tag);
    idle_cycles(3);
    check({tag, "_clear_held"}, {63'd0, o_kc_clear}, 1);
    i_err_clr = 1'b1;
    @(posedge clk); #1;
    i_err_clr = 1'b0;
    check({tag, "_ack_err"}, {63'd0, o_err}, 0);
    check({tag, "_ack_code"}, {62'd0, o_err_code}, 0);
    check({tag, "_ack_idle"}, {63'd0, o_busy}, 0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    model_reset();
    idle_cycles(2);
  endtask

  initial begin
    int n;
    // Reset state.
    idle_cycles(2);
    check("rst_kc_clear", {63'd0, o_kc_clear}, 1);
    check("rst_busy", {63'd0, o_busy}, 0);
    check("rst_err", {63'd0, o_err}, 0);
    check("rst_code", {62'd0, o_err_code}, 0);
    check("rst_win", o_win_count, 0);
    check("rst_done", {63'd0, o_frame_done}, 0);
    i_rst = 1'b0;
    idle_cycles(1);
    check("rst_kc_clear_drop", {63'd0, o_kc_clear}, 0);

    // Disarmed IDLE refuses even a SOF pixel.
    i_valid = 1'b1; i_sof = 1'b1;
    #1;
    check("disabled_ready", {63'd0, o_ready}, 0);
    check("disabled_kc_valid", {63'd0, o_kc_valid}, 0);
    idle_cycles(2);
    i_valid = 1'b0; i_sof = 1'b0;
    check("disabled_idle", {63'd0, o_busy}, 0);

    // Clean frame, no stalls.
    i_enable = 1'b1;
    send_frame(0, 0);
    wait_done("clean");

    // Backpressure: random valid gaps, random kernel stalls, enable drop mid-frame.
    kc_rand = 1;
    send_frame(0, 1);
    wait_done("bp");
    kc_rand = 0;

    // Short line, then recovery frame.
    send_frame(1, 0);
    ack_error("short");
    send_frame(0, 0);
    wait_done("after_short");

    // Pre-SOF garbage followed by a frame with an early SOF.
    for (int k = 0; k < 10; k++) send_pixel(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    check("garbage_idle", {63'd0, o_busy}, 0);
    send_frame(2, 0);
    ack_error("early_sof");

    // Drain timeout with a silent kernel.
    kc_silent = 1;
    send_frame(0, 0);
    n = 0;
    @(negedge clk);
    while (o_err !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("drain_err_timeout", 1, 0);
    check("drain_delay", cyc - last_xfer_edge, DT);
    check("drain_code", {62'd0, o_err_code}, 3);
    @(posedge clk); #1;
    kc_silent = 0;
    ack_error("drain");

    // Reset at row 4 with a pixel presented during the reset cycle.
    for (int p = 0; p < 4 * LL + 3; p++)
      send_pixel(1'($urandom_range(0, 1)), p == 0, (p % LL) == LL - 1);
    i_rst = 1'b1; i_valid = 1'b1; i_data = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_data = 1'b0;
    check("midrst_kc_clear", {63'd0, o_kc_clear}, 1);
    check("midrst_busy", {63'd0, o_busy}, 0);
    check("midrst_err", {63'd0, o_err}, 0);
    check("midrst_win", o_win_count, 0);
    check("midrst_done", {63'd0, o_frame_done}, 0);
    check("midrst_ready", {63'd0, o_ready}, 0);
    check("midrst_kc_valid", {63'd0, o_kc_valid}, 0);
    idle_cycles(1);
    check("midrst_clear_drop", {63'd0, o_kc_clear}, 0);
    check("midrst_sb_empty", exp_q.size(), 0);
    model_reset();
    i_enable = 1'b1;
    send_frame(0, 0);
    wait_done("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
